ifetch_ctrl: RTL and testbench

//  - Fetch sequencer in front of instruction_mem. Owns the PC, issues sequential word reads,
//    and buffers returned instructions in a DEPTH-entry prefetch FIFO.
//  - Hands instructions to decode over a valid/ready handshake.
//  - Handles PC redirects (branch/jump) by flushing the FIFO and refetching from the new PC.

---
 rtl/ifetch_if.sv | 26 ++
 rtl/ifetch_ctrl.sv | 128 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch sequencer bundle: memory read port, redirect request and decode handoff.
// Latency: n/a (wires only).
// Backpressure: inst_ready from decode; the memory side never stalls.
interface ifetch_if;
  logic        start;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic [15:0] stall_cnt;

  modport master (
    input  start, imem_data, redirect, redirect_pc, inst_ready,
    output imem_addr, imem_rd, inst_valid, inst, inst_pc, stall_cnt
  );

  modport slave (
    output start, imem_data, redirect, redirect_pc, inst_ready,
    input  imem_addr, imem_rd, inst_valid, inst, inst_pc, stall_cnt
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, reads sequential words into a DEPTH-entry prefetch FIFO.
// Latency: a word read in cycle N is at the FIFO head in cycle N+1; redirect refetches next cycle.
// Backpressure: inst_ready low fills the FIFO, then reads stop (FULL) until a pop. Option: IFETCH_PERF_EN.
module ifetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic     clk,
  input  logic     rst_n,
  ifetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic        not_empty;
  logic        pop;
  logic        push;
  logic [31:0] redirect_word;

  // Head presentation and the read/pop handshake decisions.
  always_comb begin
    not_empty     = (count_q != '0);
    pop           = not_empty & bus.inst_ready;
    push          = (state_q == FETCH) & ~bus.redirect & ((count_q < FULL_CNT) | pop);
    redirect_word = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  assign bus.imem_addr  = pc_q;
  assign bus.imem_rd    = push;
  assign bus.inst_valid = not_empty;
  assign bus.inst       = not_empty ? fifo_inst_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc    = not_empty ? fifo_pc_q[rd_ptr_q]   : 32'h0;

  // Next-state: FSM, PC, and FIFO pointers; redirect flushes and outranks push/pop.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) pc_d = redirect_word;
        if (bus.start)    state_d = FETCH;
      end
      default: begin
        if (bus.redirect) begin
          state_d  = FETCH;
          pc_d     = redirect_word;
          count_d  = '0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end else begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            pc_d     = pc_q + 32'd4;
          end
          if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
          case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
          endcase
          if (state_q == FULL && pop)                     state_d = FETCH;
          else if (state_q == FETCH && count_d == FULL_CNT) state_d = FULL;
        end
      end
    endcase
  end

  // Control state register with synchronous reset; queued entries are dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: outputs are masked while the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= bus.imem_data;
      fifo_pc_q[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter: FULL cycles and active redirects, saturating.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == FULL || (bus.redirect && state_q != IDLE)) && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= 16'h0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: streaming, FULL backpressure, redirect, PC wrap, reset.
// Latency: checks every cycle at negedge+1.
// Backpressure: inst_ready driven by the stimulus sequence.
module tb_ifetch_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

`ifdef IFETCH_PERF_EN
  localparam logic [31:0] EXP_STALL10 = 32'd10;
  localparam logic [31:0] EXP_STALL11 = 32'd11;
`else
  localparam logic [31:0] EXP_STALL10 = 32'd0;
  localparam logic [31:0] EXP_STALL11 = 32'd0;
`endif

  always #5 clk = ~clk;

  ifetch_if bus ();
  ifetch_if wbus ();

  // Memory model: mem[i] = i for word index i.
  assign bus.imem_data  = {2'b00, bus.imem_addr[31:2]};
  assign wbus.imem_data = {2'b00, wbus.imem_addr[31:2]};

  ifetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  ifetch_ctrl #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (wbus.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b0; wbus.start = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] waddr;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b1;
    wbus.start = 1'b0; wbus.redirect = 1'b0; wbus.redirect_pc = 32'h0; wbus.inst_ready = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("rst_inst",  bus.inst,                32'h0);
    chk("rst_pc",    bus.inst_pc,             32'h0);
    chk("rst_rd",    {31'b0, bus.imem_rd},    32'h0);
    chk("rst_addr",  bus.imem_addr,           32'h0);
    chk("rst_stall", {16'b0, bus.stall_cnt},  32'h0);
    chk("rst_waddr", wbus.imem_addr,          32'hFFFF_FFF8);

    // Streaming with inst_ready=1, plus wrap instance
    @(negedge clk);
    bus.start = 1'b1; wbus.start = 1'b1; bus.inst_ready = 1'b1;
    #1;
    chk("idle_rd", {31'b0, bus.imem_rd}, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.start = 1'b0; wbus.start = 1'b0;
      #1;
      chk("str_rd",   {31'b0, bus.imem_rd}, 32'h1);
      chk("str_addr", bus.imem_addr, 32'(4 * c));
      if (c == 0) begin
        chk("str_valid0", {31'b0, bus.inst_valid}, 32'h0);
      end else begin
        chk("str_valid", {31'b0, bus.inst_valid}, 32'h1);
        chk("str_ipc",   bus.inst_pc, 32'(4 * (c - 1)));
        chk("str_inst",  bus.inst,    32'(c - 1));
      end
      if (c < 3) begin
        waddr = 32'hFFFF_FFF8 + 32'(4 * c);
        chk("wrap_addr", wbus.imem_addr, waddr);
        chk("wrap_rd",   {31'b0, wbus.imem_rd}, 32'h1);
      end
    end

    // Fill with inst_ready=0, hold FULL, then redirect
    do_reset();
    @(negedge clk);
    bus.start = 1'b1; bus.inst_ready = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("fill_rd",   {31'b0, bus.imem_rd}, 32'h1);
      chk("fill_addr", bus.imem_addr, 32'(4 * c));
    end
    for (int c = 4; c < 14; c++) begin
      @(negedge clk);
      #1;
      chk("full_rd",   {31'b0, bus.imem_rd}, 32'h0);
      chk("full_addr", bus.imem_addr, 32'h10);
      chk("full_ipc",  bus.inst_pc, 32'h0);
      if (c == 4) chk("stall_c4", {16'b0, bus.stall_cnt}, 32'h0);
    end
    @(negedge clk);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
    #1;
    chk("stall10",  {16'b0, bus.stall_cnt}, EXP_STALL10);
    chk("redir_rd", {31'b0, bus.imem_rd}, 32'h0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("stall11",    {16'b0, bus.stall_cnt}, EXP_STALL11);
    chk("rdf_valid",  {31'b0, bus.inst_valid}, 32'h0);
    chk("rdf_addr",   bus.imem_addr, 32'h100);
    chk("rdf_rd",     {31'b0, bus.imem_rd}, 32'h1);
    @(negedge clk);
    #1;
    chk("rdf_ipc",  bus.inst_pc, 32'h100);
    chk("rdf_inst", bus.inst,    32'h40);
    chk("rdf_addr2", bus.imem_addr, 32'h104);
    @(negedge clk);
    @(negedge clk);
    // cycle 19: FULL again, pop one
    @(negedge clk);
    bus.inst_ready = 1'b1;
    #1;
    chk("pop_rd",   {31'b0, bus.imem_rd}, 32'h0);
    chk("pop_addr", bus.imem_addr, 32'h110);
    chk("pop_ipc",  bus.inst_pc, 32'h100);
    // cycle 20: refetch after pop, then redirect with 3 queued
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    chk("refetch_rd",   {31'b0, bus.imem_rd}, 32'h1);
    chk("refetch_addr", bus.imem_addr, 32'h110);
    chk("refetch_ipc",  bus.inst_pc, 32'h104);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
    #1;
    chk("redir3_rd", {31'b0, bus.imem_rd}, 32'h0);
    @(negedge clk);
    bus.redirect = 1'b0;
    #1;
    chk("r3_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("r3_addr",  bus.imem_addr, 32'h200);
    chk("r3_rd",    {31'b0, bus.imem_rd}, 32'h1);
    @(negedge clk);
    #1;
    chk("r3_ipc",   bus.inst_pc, 32'h200);
    chk("r3_inst",  bus.inst, 32'h80);
    @(negedge clk);
    @(negedge clk);
    // cycle 25: FULL, then reset for one cycle
    @(negedge clk);
    #1;
    chk("full2_rd",   {31'b0, bus.imem_rd}, 32'h0);
    chk("full2_addr", bus.imem_addr, 32'h210);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_valid", {31'b0, bus.inst_valid}, 32'h0);
    chk("mrst_rd",    {31'b0, bus.imem_rd}, 32'h0);
    chk("mrst_addr",  bus.imem_addr, 32'h0);
    chk("mrst_inst",  bus.inst, 32'h0);
    chk("mrst_stall", {16'b0, bus.stall_cnt}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("idle_hold_rd",   {31'b0, bus.imem_rd}, 32'h0);
      chk("idle_hold_addr", bus.imem_addr, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
